axil_protocol_monitor: RTL and testbench
========================================

AXIL_PROTOCOL_MONITOR -- requirements
Module: axil_protocol_monitor

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, RDATA/WDATA width.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, ARADDR/AWADDR width.
REQ-003 SHALL have parameter MAX_WAIT, default 5, the allowed consecutive VALID-without-READY cycles on AR/AW/W.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, the outstanding-transaction limit per direction.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, the completed-transaction counter width.
REQ-006 SHALL have ports:
- AXI_ACLK  in  1  sole clock, rising edge.
- AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have AXI-Lite inputs, all observe-only:
- AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RVALID/RREADY.
- AXI_AWADDR/AWVALID/AWREADY, AXI_WDATA/WVALID/WREADY.
- AXI_BRESP[1:0]/BVALID/BREADY.
REQ-008 SHALL have CLEAR  in  1  synchronous clear of the error state.
REQ-009 SHALL have ERR_STICKY  out  11  sticky per-rule violation flags.
REQ-010 SHALL have ERR_PULSE  out  1  high for one cycle after any violation is sampled.
REQ-011 SHALL have FIRST_ERR  out  4  index of the first violation since reset/CLEAR; 4'hF when none.
REQ-012 SHALL have RD_COUNT, WR_COUNT  out  CNT_WIDTH each  completed R and B handshakes, wrapping modulo 2^CNT_WIDTH.

Function
REQ-013 SHALL define a handshake as VALID&&READY sampled at a rising edge; a pending beat is VALID&&!READY sampled at an edge.
REQ-014 SHALL keep a stall counter per AR, AW and W channel:
- increments on each pending beat; clears on handshake or VALID low; saturates at MAX_WAIT+1.
- stall error bits: 0 = AR, 2 = AW, 4 = W.
- a stall error is set at the edge where the (MAX_WAIT+1)th consecutive pending beat is sampled.
REQ-015 SHALL register VALID-pending and payload per channel; a stability error is set when the previous edge held a pending beat and, at the current edge, VALID is low or the payload differs.
- payloads: ARADDR, AWADDR, WDATA, RDATA, BRESP.
- stability error bits: 1 = AR, 3 = AW, 5 = W, 6 = R, 7 = B.
REQ-016 SHALL track rd_out as follows: +1 on AR handshake, -1 on R handshake, unchanged when both occur at the same edge.
REQ-017 SHALL track aw_out and w_out independently; each is incremented by its own handshake; both are decremented on a B handshake.
REQ-018 SHALL set bit 8 when RVALID is sampled high with rd_out==0 and no simultaneous AR handshake; rd_out then holds at 0.
REQ-019 SHALL set bit 9 when BVALID is sampled high with aw_out==0 or w_out==0, excluding a same-edge handshake that makes both nonzero; counts hold at 0.
REQ-020 SHALL set bit 10 when an AR, AW or W handshake would take its count above MAX_OUTSTANDING; that count holds at MAX_OUTSTANDING.
REQ-021 SHALL set ERR_STICKY bits at the sampling edge, visible in the following cycle; a bit stays set until CLEAR or reset.
REQ-022 SHALL drive ERR_PULSE high for exactly the cycle after any edge at which one or more rules fire, even when those bits are already sticky.
REQ-023 SHALL load FIRST_ERR with the lowest-index bit firing at an edge only while FIRST_ERR==4'hF; later violations do not change it.
REQ-024 SHALL have CLEAR zero ERR_STICKY and set FIRST_ERR=4'hF at the next edge.
- a violation at the same edge wins: its bit is set, and FIRST_ERR takes its index.
- CLEAR does not affect outstanding counts, stall counters or RD_COUNT/WR_COUNT.
REQ-025 SHALL increment RD_COUNT on every R handshake and WR_COUNT on every B handshake, including handshakes that raise bit 8 or 9.
REQ-026 SHALL never drive any AXI signal; the module is a passive observer.

Reset
REQ-027 SHALL, while AXI_ARESET is high, asynchronously force:
- ERR_STICKY=0, ERR_PULSE=0, FIRST_ERR=4'hF, RD_COUNT=0, WR_COUNT=0.
- all stall counters, outstanding counts and pending registers = 0.
REQ-028 SHALL evaluate no rule at the first edge after reset deassertion, except counting handshakes; an in-flight transaction cut by reset is forgotten.

Verification (MAX_WAIT=5, MAX_OUTSTANDING=4)
REQ-029 SHALL cover: ARVALID=1 with ARREADY=0 for 6 edges -> ERR_STICKY[0]=1, ERR_PULSE one cycle, FIRST_ERR=0; with 5 edges then ARREADY=1 -> no error.
REQ-030 SHALL cover: AWADDR 0x10 pending, then 0x14 while AWVALID=1 -> ERR_STICKY[3]=1; WVALID dropped while pending -> ERR_STICKY[5]=1, FIRST_ERR stays 3.
REQ-031 SHALL cover: 5 AR handshakes without R -> ERR_STICKY[10]=1; then 4 R handshakes -> rd_out=0, RD_COUNT=4; a further RVALID -> ERR_STICKY[8]=1.
REQ-032 SHALL cover: AW, then W two cycles later, then B handshake -> WR_COUNT=1, no error; BVALID with only AW done -> ERR_STICKY[9]=1.
REQ-033 SHALL cover: CLEAR and a new W stall error at the same edge -> ERR_STICKY=0x010, FIRST_ERR=4.
REQ-034 SHALL cover: AXI_ARESET asserted mid-transaction between edges -> outputs reset immediately; after release, an R handshake with no AR -> bit 8 set, RD_COUNT=1.

Source files
------------

// File: rtl/axil_protocol_monitor.sv
// axil_protocol_monitor
//   Passive AXI4-Lite protocol checker. It samples every channel at each
//   rising edge and flags rule violations. It never drives the bus.
//
// Ports
//   AXI_ACLK, AXI_ARESET    : clock, asynchronous active-high reset
//   AXI_AR*/R*/AW*/W*/B*    : observed AXI-Lite channels (all inputs)
//   CLEAR                   : synchronous clear of ERR_STICKY / FIRST_ERR
//   ERR_STICKY[10:0]        : sticky per-rule flags
//                               0 AR stall    1 AR stability
//                               2 AW stall    3 AW stability
//                               4 W stall     5 W stability
//                               6 R stability 7 B stability
//                               8 R without outstanding AR
//                               9 B without outstanding AW and W
//                               10 outstanding limit exceeded
//   ERR_PULSE               : one cycle high after any edge where a rule fired
//   FIRST_ERR[3:0]          : lowest rule index of the first violating edge, 4'hF if none
//   RD_COUNT, WR_COUNT      : completed R / B handshakes, wrapping
module axil_protocol_monitor #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 8,
   parameter int MAX_WAIT         = 5,
   parameter int MAX_OUTSTANDING  = 4,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                        AXI_ACLK,
   input  logic                        AXI_ARESET,
   input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
   input  logic                        AXI_ARVALID,
   input  logic                        AXI_ARREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
   input  logic                        AXI_RVALID,
   input  logic                        AXI_RREADY,
   input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
   input  logic                        AXI_AWVALID,
   input  logic                        AXI_AWREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
   input  logic                        AXI_WVALID,
   input  logic                        AXI_WREADY,
   input  logic [1:0]                  AXI_BRESP,
   input  logic                        AXI_BVALID,
   input  logic                        AXI_BREADY,
   input  logic                        CLEAR,
   output logic [10:0]                 ERR_STICKY,
   output logic                        ERR_PULSE,
   output logic [3:0]                  FIRST_ERR,
   output logic [CNT_WIDTH-1:0]        RD_COUNT,
   output logic [CNT_WIDTH-1:0]        WR_COUNT
);

   localparam int SW = $clog2(MAX_WAIT + 2);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [SW-1:0] STALL_FIRE = SW'(MAX_WAIT);
   localparam logic [SW-1:0] STALL_SAT  = SW'(MAX_WAIT + 1);
   localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);

   // handshakes and pending beats
   logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
   logic w_ar_pend, w_r_pend, w_aw_pend, w_w_pend, w_b_pend;

   assign w_ar_hs   = AXI_ARVALID &  AXI_ARREADY;
   assign w_r_hs    = AXI_RVALID  &  AXI_RREADY;
   assign w_aw_hs   = AXI_AWVALID &  AXI_AWREADY;
   assign w_w_hs    = AXI_WVALID  &  AXI_WREADY;
   assign w_b_hs    = AXI_BVALID  &  AXI_BREADY;
   assign w_ar_pend = AXI_ARVALID & ~AXI_ARREADY;
   assign w_r_pend  = AXI_RVALID  & ~AXI_RREADY;
   assign w_aw_pend = AXI_AWVALID & ~AXI_AWREADY;
   assign w_w_pend  = AXI_WVALID  & ~AXI_WREADY;
   assign w_b_pend  = AXI_BVALID  & ~AXI_BREADY;

   // registered state
   logic                        r_armed;
   logic [SW-1:0]               r_stall [3];
   logic                        r_pend_ar, r_pend_aw, r_pend_w, r_pend_r, r_pend_b;
   logic [C_AXI_ADDR_WIDTH-1:0] r_araddr, r_awaddr;
   logic [C_AXI_DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic [1:0]                  r_bresp;
   logic [OW-1:0]               r_rd_out, r_aw_out, r_w_out;
   logic [10:0]                 r_sticky;
   logic                        r_pulse;
   logic [3:0]                  r_first;
   logic [CNT_WIDTH-1:0]        r_rd_cnt, r_wr_cnt;

   // stall tracking, channel order AR, AW, W
   logic [2:0] w_pend3;
   logic [2:0] w_stall_fire;
   assign w_pend3 = {w_w_pend, w_aw_pend, w_ar_pend};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_stall_fire[i] = w_pend3[i] && (r_stall[i] == STALL_FIRE);
      end
   end

   // stability: a beat pending last edge must still be valid with the same payload
   logic w_stab_ar, w_stab_aw, w_stab_w, w_stab_r, w_stab_b;
   assign w_stab_ar = r_pend_ar && (!AXI_ARVALID || (AXI_ARADDR != r_araddr));
   assign w_stab_aw = r_pend_aw && (!AXI_AWVALID || (AXI_AWADDR != r_awaddr));
   assign w_stab_w  = r_pend_w  && (!AXI_WVALID  || (AXI_WDATA  != r_wdata));
   assign w_stab_r  = r_pend_r  && (!AXI_RVALID  || (AXI_RDATA  != r_rdata));
   assign w_stab_b  = r_pend_b  && (!AXI_BVALID  || (AXI_BRESP  != r_bresp));

   // outstanding counter step: returns {overflow, next}; holds at 0 and at OUT_MAX
   function automatic logic [OW:0] out_step(input logic [OW-1:0] cnt,
                                            input logic inc, input logic dec);
      logic [OW:0] res;
      res = {1'b0, cnt};
      if (inc && !dec) begin
         if (cnt == OUT_MAX) res[OW] = 1'b1;
         else                res[OW-1:0] = cnt + OW'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         res[OW-1:0] = cnt - OW'(1);
      end
      return res;
   endfunction

   logic [OW:0] w_rd_step, w_aw_step, w_w_step;
   assign w_rd_step = out_step(r_rd_out, w_ar_hs, w_r_hs);
   assign w_aw_step = out_step(r_aw_out, w_aw_hs, w_b_hs);
   assign w_w_step  = out_step(r_w_out,  w_w_hs,  w_b_hs);

   // a same-edge request handshake counts as already outstanding
   logic w_r_orphan, w_b_orphan, w_ovf;
   assign w_r_orphan = AXI_RVALID && (r_rd_out == '0) && !w_ar_hs;
   assign w_b_orphan = AXI_BVALID && (((r_aw_out == '0) && !w_aw_hs) ||
                                      ((r_w_out  == '0) && !w_w_hs));
   assign w_ovf      = w_rd_step[OW] | w_aw_step[OW] | w_w_step[OW];

   // nothing is judged on the first edge out of reset
   logic [10:0] w_fire;
   assign w_fire = r_armed ? {w_ovf, w_b_orphan, w_r_orphan, w_stab_b, w_stab_r,
                              w_stab_w, w_stall_fire[2], w_stab_aw, w_stall_fire[1],
                              w_stab_ar, w_stall_fire[0]}
                           : 11'd0;

   logic [3:0] w_first_idx;
   always_comb begin
      w_first_idx = 4'hF;
      for (int i = 10; i >= 0; i--) begin
         if (w_fire[i]) w_first_idx = 4'(i);
      end
   end

   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         r_armed   <= 1'b0;
         for (int i = 0; i < 3; i++) r_stall[i] <= '0;
         r_pend_ar <= 1'b0;
         r_pend_aw <= 1'b0;
         r_pend_w  <= 1'b0;
         r_pend_r  <= 1'b0;
         r_pend_b  <= 1'b0;
         r_araddr  <= '0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_bresp   <= '0;
         r_rd_out  <= '0;
         r_aw_out  <= '0;
         r_w_out   <= '0;
         r_sticky  <= '0;
         r_pulse   <= 1'b0;
         r_first   <= 4'hF;
         r_rd_cnt  <= '0;
         r_wr_cnt  <= '0;
      end else begin
         r_armed <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (!w_pend3[i])                r_stall[i] <= '0;
            else if (r_stall[i] != STALL_SAT) r_stall[i] <= r_stall[i] + SW'(1);
         end
         r_pend_ar <= w_ar_pend;
         r_pend_aw <= w_aw_pend;
         r_pend_w  <= w_w_pend;
         r_pend_r  <= w_r_pend;
         r_pend_b  <= w_b_pend;
         r_araddr  <= AXI_ARADDR;
         r_awaddr  <= AXI_AWADDR;
         r_wdata   <= AXI_WDATA;
         r_rdata   <= AXI_RDATA;
         r_bresp   <= AXI_BRESP;
         r_rd_out  <= w_rd_step[OW-1:0];
         r_aw_out  <= w_aw_step[OW-1:0];
         r_w_out   <= w_w_step[OW-1:0];
         r_sticky  <= CLEAR ? w_fire : (r_sticky | w_fire);
         r_pulse   <= |w_fire;
         // with CLEAR and no violation, w_first_idx is 4'hF
         if (CLEAR || (r_first == 4'hF)) r_first <= w_first_idx;
         if (w_r_hs) r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
         if (w_b_hs) r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
      end
   end

   assign ERR_STICKY = r_sticky;
   assign ERR_PULSE  = r_pulse;
   assign FIRST_ERR  = r_first;
   assign RD_COUNT   = r_rd_cnt;
   assign WR_COUNT   = r_wr_cnt;

endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Testbench for axil_protocol_monitor: directed scenarios with fixed expected
// values, then randomized traffic compared every cycle to a reference model.
module tb_axil_protocol_monitor;

   localparam int MAX_WAIT = 5;
   localparam int MAX_OUT  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  araddr, awaddr;
   logic [31:0] rdata, wdata;
   logic [1:0]  bresp;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wvalid, wready, bvalid, bready, clr;
   logic [10:0] err_sticky;
   logic        err_pulse;
   logic [3:0]  first_err;
   logic [15:0] rd_count, wr_count;

   always #5 clk = ~clk;

   axil_protocol_monitor dut (
      .AXI_ACLK(clk), .AXI_ARESET(rst),
      .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
      .AXI_RDATA(rdata), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
      .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
      .AXI_WDATA(wdata), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
      .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
      .CLEAR(clr), .ERR_STICKY(err_sticky), .ERR_PULSE(err_pulse),
      .FIRST_ERR(first_err), .RD_COUNT(rd_count), .WR_COUNT(wr_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // channel index: 0 AR, 1 AW, 2 W, 3 R, 4 B
   logic [10:0] m_sticky;
   logic        m_pulse;
   int          m_first, m_rdc, m_wrc;
   int          run [3];
   bit          prev_pend [5];
   logic [31:0] prev_pay [5];
   int          rd_out, aw_out, w_out;
   bit          armed;

   function automatic int lowest(input logic [10:0] f);
      for (int i = 0; i < 11; i++) if (f[i]) return i;
      return 15;
   endfunction

   function automatic int clamp(input int v, input int hi);
      if (v < 0)  return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      m_sticky = '0; m_pulse = 0; m_first = 15; m_rdc = 0; m_wrc = 0;
      for (int i = 0; i < 3; i++) run[i] = 0;
      for (int i = 0; i < 5; i++) begin prev_pend[i] = 0; prev_pay[i] = '0; end
      rd_out = 0; aw_out = 0; w_out = 0; armed = 0;
   endtask

   task automatic model_step();
      logic [4:0]  v, r, hs;
      logic [31:0] p [5];
      logic [10:0] fire;
      int          n;
      v = {bvalid, rvalid, wvalid, awvalid, arvalid};
      r = {bready, rready, wready, awready, arready};
      hs = v & r;
      p[0] = {24'd0, araddr}; p[1] = {24'd0, awaddr}; p[2] = wdata; p[3] = rdata;
      p[4] = {30'd0, bresp};
      fire = '0;
      for (int i = 0; i < 3; i++) begin
         run[i] = (v[i] && !r[i]) ? run[i] + 1 : 0;
         if (run[i] == MAX_WAIT + 1) fire[2*i] = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
         if (prev_pend[i] && (!v[i] || p[i] != prev_pay[i]))
            fire[(i < 3) ? 2*i + 1 : i + 3] = 1'b1;
         prev_pend[i] = v[i] && !r[i];
         prev_pay[i]  = p[i];
      end
      if (v[3] && rd_out == 0 && !hs[0]) fire[8] = 1'b1;
      if (v[4] && ((aw_out + int'(hs[1]) == 0) || (w_out + int'(hs[2]) == 0))) fire[9] = 1'b1;
      n = rd_out + int'(hs[0]) - int'(hs[3]);
      if (n > MAX_OUT) fire[10] = 1'b1;
      rd_out = clamp(n, MAX_OUT);
      n = aw_out + int'(hs[1]) - int'(hs[4]);
      if (n > MAX_OUT) fire[10] = 1'b1;
      aw_out = clamp(n, MAX_OUT);
      n = w_out + int'(hs[2]) - int'(hs[4]);
      if (n > MAX_OUT) fire[10] = 1'b1;
      w_out = clamp(n, MAX_OUT);
      if (!armed) fire = '0;
      armed = 1;
      m_rdc = (m_rdc + int'(hs[3])) % 65536;
      m_wrc = (m_wrc + int'(hs[4])) % 65536;
      m_pulse = |fire;
      if (clr) begin
         m_sticky = fire;
         m_first  = lowest(fire);
      end else begin
         m_sticky = m_sticky | fire;
         if (m_first == 15) m_first = lowest(fire);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic compare_all();
      check_val("sticky", 32'(err_sticky), 32'(m_sticky));
      check_val("pulse",  32'(err_pulse),  32'(m_pulse));
      check_val("first",  32'(first_err),  32'(m_first));
      check_val("rd_cnt", 32'(rd_count),   32'(m_rdc));
      check_val("wr_cnt", 32'(wr_count),   32'(m_wrc));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_all();
   endtask

   task automatic idle();
      arvalid = 0; arready = 0; rvalid = 0; rready = 0; awvalid = 0; awready = 0;
      wvalid = 0; wready = 0; bvalid = 0; bready = 0; clr = 0;
      araddr = '0; awaddr = '0; rdata = '0; wdata = '0; bresp = '0;
   endtask

   task automatic do_reset();
      rst = 1; idle(); model_reset();
      #1;
      compare_all();
      tick();
      rst = 0;
   endtask

   task automatic rnd_ch(input logic v_in, input logic rdy_in, input logic [31:0] p_in,
                         output logic v_out, output logic [31:0] p_out);
      if (v_in && !rdy_in && $urandom_range(0, 15) != 0) begin
         v_out = 1'b1; p_out = p_in;
      end else begin
         v_out = ($urandom_range(0, 1) == 0);
         p_out = 32'($urandom_range(0, 3));
      end
   endtask

   initial begin
      logic [31:0] pv;
      logic        vv;
      int          bias;

      // AR stall: 5 pending then handshake is legal; 6 pending fires bit 0
      do_reset(); tick();
      arvalid = 1; araddr = 8'h20;
      repeat (5) tick();
      arready = 1; tick();
      check_val("ar5_no_err", 32'(err_sticky), 32'h0);
      arready = 0;
      repeat (6) tick();
      check_val("ar6_sticky", 32'(err_sticky), 32'h001);
      check_val("ar6_pulse",  32'(err_pulse),  32'h1);
      check_val("ar6_first",  32'(first_err),  32'h0);
      arready = 1; tick();
      check_val("ar_pulse_drop", 32'(err_pulse), 32'h0);

      // AW address change and W drop while pending
      do_reset(); tick();
      awvalid = 1; awaddr = 8'h10; tick();
      awaddr = 8'h14; tick();
      check_val("aw_stab", 32'(err_sticky), 32'h008);
      check_val("aw_first", 32'(first_err), 32'h3);
      awready = 1; tick();
      awvalid = 0; awready = 0; wvalid = 1; wdata = 32'hA5; tick();
      wvalid = 0; tick();
      check_val("w_stab", 32'(err_sticky), 32'h028);
      check_val("w_first", 32'(first_err), 32'h3);

      // read outstanding overflow, drain, orphan R
      do_reset(); tick();
      arvalid = 1; arready = 1;
      repeat (5) tick();
      check_val("rd_ovf", 32'(err_sticky), 32'h400);
      arvalid = 0; arready = 0; rvalid = 1; rready = 1;
      repeat (4) tick();
      check_val("rd_drain_cnt", 32'(rd_count), 32'd4);
      check_val("rd_drain_err", 32'(err_sticky), 32'h400);
      tick();
      check_val("r_orphan", 32'(err_sticky), 32'h500);
      check_val("r_orphan_cnt", 32'(rd_count), 32'd5);

      // write path: AW, W two cycles later, B; then B with only AW
      do_reset(); tick();
      awvalid = 1; awready = 1; tick();
      awvalid = 0; awready = 0; tick();
      wvalid = 1; wready = 1; tick();
      wvalid = 0; wready = 0; bvalid = 1; bready = 1; tick();
      check_val("wr_ok_cnt", 32'(wr_count), 32'd1);
      check_val("wr_ok_err", 32'(err_sticky), 32'h0);
      bvalid = 0; bready = 0; awvalid = 1; awready = 1; tick();
      awvalid = 0; awready = 0; bvalid = 1; bready = 1; tick();
      check_val("b_orphan", 32'(err_sticky), 32'h200);
      check_val("b_orphan_cnt", 32'(wr_count), 32'd2);

      // CLEAR coinciding with a new W stall error
      do_reset(); tick();
      rvalid = 1; rready = 1; tick();
      check_val("pre_clear_first", 32'(first_err), 32'h8);
      rvalid = 0; rready = 0; tick();
      wvalid = 1; wdata = 32'h55;
      repeat (5) tick();
      clr = 1; tick();
      check_val("clr_sticky", 32'(err_sticky), 32'h010);
      check_val("clr_first",  32'(first_err),  32'h4);
      clr = 0; wready = 1; tick();
      idle();

      // asynchronous reset mid-transaction
      do_reset(); tick();
      rvalid = 1; rready = 1; tick();
      rvalid = 0; rready = 0; arvalid = 1; arready = 1; tick();
      arready = 0; araddr = 8'h33; tick();
      #2 rst = 1; model_reset();
      #1;
      check_val("async_sticky", 32'(err_sticky), 32'h0);
      check_val("async_first",  32'(first_err),  32'hF);
      check_val("async_rdcnt",  32'(rd_count),   32'h0);
      check_val("async_pulse",  32'(err_pulse),  32'h0);
      idle(); tick();
      rst = 0; tick();
      rvalid = 1; rready = 1; tick();
      check_val("post_rst_r", 32'(err_sticky), 32'h100);
      check_val("post_rst_cnt", 32'(rd_count), 32'd1);
      idle();

      // randomized traffic against the model
      do_reset();
      bias = 4;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 150 == 0) bias = $urandom_range(1, 8);
         rnd_ch(arvalid, arready, {24'd0, araddr}, vv, pv); arvalid = vv; araddr = pv[7:0];
         rnd_ch(awvalid, awready, {24'd0, awaddr}, vv, pv); awvalid = vv; awaddr = pv[7:0];
         rnd_ch(wvalid, wready, wdata, vv, pv); wvalid = vv; wdata = pv;
         rnd_ch(rvalid, rready, rdata, vv, pv); rvalid = vv; rdata = pv;
         rnd_ch(bvalid, bready, {30'd0, bresp}, vv, pv); bvalid = vv; bresp = pv[1:0];
         arready = ($urandom_range(0, 7) < bias);
         awready = ($urandom_range(0, 7) < bias);
         wready  = ($urandom_range(0, 7) < bias);
         rready  = ($urandom_range(0, 7) < bias);
         bready  = ($urandom_range(0, 7) < bias);
         clr     = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 599) == 0) do_reset();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
